gblcd_line_out: RTL and testbench

- Downstream consumer of the Game Boy capture stage.
- On each read-row request, reads one 160-pixel row from the shared 4-line line RAM and maps each 2-bit shade to RGB565 through a fixed palette.
- Horizontally replicates each pixel HSCALE times and streams the result to the panel interface over a valid/ready handshake.
- Pulses line_done after the last pixel is accepted; this pulse paces the capture stage's fill/flush state machine.

---
 rtl/gblcd_pkg.sv | 50 +++++
 rtl/gblcd_skid_buf.sv | 60 ++++++
 rtl/gblcd_line_out.sv | 176 +++++++++++++++++
 tb/tb_gblcd_line_out.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gblcd_pkg.sv
// Shared constants, palette, state encoding and pixel types for the Game Boy line output path.
package gblcd_pkg;

    localparam int SRC_W   = 160;
    localparam int HSCALE  = 2;
    localparam int OUT_W   = SRC_W * HSCALE;
    localparam int LRAM_AW = 10;
    localparam int COL_W   = 8;
    localparam int BEAT_W  = 9;
    localparam int REP_W   = (HSCALE > 1) ? $clog2(HSCALE) : 1;

    localparam logic [15:0] PAL_SHADE0 = 16'hFFFF;
    localparam logic [15:0] PAL_SHADE1 = 16'hAD55;
    localparam logic [15:0] PAL_SHADE2 = 16'h52AA;
    localparam logic [15:0] PAL_SHADE3 = 16'h0000;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        STREAM,
        DRAIN,
        DONE
    } line_state_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    function automatic rgb565_t shade_to_rgb(input logic [1:0] shade);
        rgb565_t c;
        case (shade)
            2'd0:    c = PAL_SHADE0;
            2'd1:    c = PAL_SHADE1;
            2'd2:    c = PAL_SHADE2;
            default: c = PAL_SHADE3;
        endcase
        return c;
    endfunction

    function automatic rgb565_t dim_rgb(input rgb565_t c);
        rgb565_t d;
        d.r = c.r >> 1;
        d.g = c.g >> 1;
        d.b = c.b >> 1;
        return d;
    endfunction

endpackage

// File: rtl/gblcd_skid_buf.sv
// Two-entry valid/ready skid buffer for RGB565 pixels; flush empties it without touching stored data.
module gblcd_skid_buf
    import gblcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       in_valid,
    input  rgb565_t    in_data,
    output logic       out_valid,
    output rgb565_t    out_data,
    input  logic       out_ready,
    output logic [1:0] count
);

    rgb565_t    head_q;
    rgb565_t    tail_q;
    logic [1:0] cnt_q;
    logic       push;
    logic       pop;

    assign push      = in_valid && (cnt_q != 2'd2);
    assign pop       = out_ready && (cnt_q != 2'd0);
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = head_q;
    assign count     = cnt_q;

    // head_q is always the oldest entry so the consumer sees a stable word until it pops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else if (flush) begin
            cnt_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) head_q <= in_data;
                    else               tail_q <= in_data;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        head_q <= in_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/gblcd_line_out.sv
// Reads one 160-pixel row from the line RAM, maps shades to RGB565, replicates horizontally and streams it.
// Optional scanline dimming of even_line rows is enabled with `define GBLCD_SCANLINE_DIM_EN.
module gblcd_line_out
    import gblcd_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame,
    input  logic [7:0]         rrow,
    input  logic               r_row_inc,
    input  logic               even_line,
    output logic [LRAM_AW-1:0] lram_ra,
    input  logic [1:0]         lram_do,
    output logic               line_done,
    output logic [15:0]        pix_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic               pix_sol,
    output logic               req_ovf
);

    line_state_t       state;
    logic [1:0]        row_q;
    logic [1:0]        pend_row;
    logic [COL_W-1:0]  col;
    logic [REP_W-1:0]  rep;
    logic [BEAT_W-1:0] beat_cnt;
    logic              pending;
    logic              pend_cap;
    logic              use_pend;
    logic              rd_vld;
    logic [1:0]        buf_cnt;
    logic [1:0]        inflight;
    logic              issue;
    logic              accept;
    logic              last_rep;
    logic              pop;
    logic              buf_valid;
    rgb565_t           rd_rgb;
    rgb565_t           buf_out;
    logic              unused_inputs;

    // A read is only launched when its data is guaranteed a free slot on arrival
    assign inflight  = buf_cnt + {1'b0, rd_vld};
    assign issue     = (state == STREAM) && (inflight <= 2'd1);
    assign accept    = buf_valid && pix_ready;
    assign last_rep  = (rep == REP_W'(HSCALE - 1));
    assign pop       = accept && last_rep;
    assign lram_ra   = {row_q, col};
    assign pix_valid = buf_valid;
    assign pix_data  = buf_out;
    assign pix_sol   = buf_valid && (beat_cnt == '0);

`ifdef GBLCD_SCANLINE_DIM_EN
    logic line_dim;
    logic pend_dim;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_dim <= 1'b0;
            pend_dim <= 1'b0;
        end else if (!frame) begin
            if (r_row_inc && (state != IDLE) && !pending) pend_dim <= even_line;
            if ((state == IDLE) && !pending && r_row_inc) line_dim <= even_line;
            if ((state == ARM) && use_pend)               line_dim <= pend_dim;
        end
    end

    assign rd_rgb        = line_dim ? dim_rgb(shade_to_rgb(lram_do)) : shade_to_rgb(lram_do);
    assign unused_inputs = ^rrow[7:2];
`else
    assign rd_rgb        = shade_to_rgb(lram_do);
    assign unused_inputs = ^{rrow[7:2], even_line};
`endif

    gblcd_skid_buf u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (frame),
        .in_valid  (rd_vld),
        .in_data   (rd_rgb),
        .out_valid (buf_valid),
        .out_data  (buf_out),
        .out_ready (pop),
        .count     (buf_cnt)
    );

    // A request arriving while busy is parked; its row is captured the cycle after, when rrow is valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            row_q     <= 2'd0;
            pend_row  <= 2'd0;
            col       <= '0;
            rep       <= '0;
            beat_cnt  <= '0;
            pending   <= 1'b0;
            pend_cap  <= 1'b0;
            use_pend  <= 1'b0;
            rd_vld    <= 1'b0;
            line_done <= 1'b0;
            req_ovf   <= 1'b0;
        end else if (frame) begin
            state     <= IDLE;
            col       <= '0;
            rep       <= '0;
            beat_cnt  <= '0;
            pending   <= 1'b0;
            pend_cap  <= 1'b0;
            use_pend  <= 1'b0;
            rd_vld    <= 1'b0;
            line_done <= 1'b0;
            req_ovf   <= 1'b0;
        end else begin
            line_done <= 1'b0;
            rd_vld    <= issue;
            if (issue) col <= col + 1'b1;
            if (accept) begin
                rep      <= last_rep ? '0 : rep + 1'b1;
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (pend_cap) begin
                pend_row <= rrow[1:0];
                pend_cap <= 1'b0;
            end
            if (r_row_inc && !((state == IDLE) && !pending)) begin
                if (pending) begin
                    req_ovf <= 1'b1;
                end else begin
                    pending  <= 1'b1;
                    pend_cap <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (pending) begin
                        state    <= ARM;
                        use_pend <= 1'b1;
                        pending  <= 1'b0;
                    end else if (r_row_inc) begin
                        state    <= ARM;
                        use_pend <= 1'b0;
                    end
                end
                ARM: begin
                    row_q    <= use_pend ? pend_row : rrow[1:0];
                    col      <= '0;
                    rep      <= '0;
                    beat_cnt <= '0;
                    state    <= STREAM;
                end
                STREAM: begin
                    if (issue && (col == COL_W'(SRC_W - 1))) state <= DRAIN;
                end
                DRAIN: begin
                    if (accept && (beat_cnt == BEAT_W'(OUT_W - 1))) begin
                        state     <= DONE;
                        line_done <= 1'b1;
                    end
                end
                DONE: begin
                    if (pending) begin
                        state    <= ARM;
                        use_pend <= 1'b1;
                        pending  <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gblcd_line_out.sv
// Scoreboard bench for gblcd_line_out: a line-level reference model queues expected beats, a monitor checks them.
module tb_gblcd_line_out;

    localparam int SRC  = 160;
    localparam int REPS = 2;
    localparam int OUTW = SRC * REPS;
    localparam int PAL [4] = '{32'hFFFF, 32'hAD55, 32'h52AA, 32'h0000};

    typedef struct {
        logic [15:0] data;
        logic        sol;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame;
    logic [7:0]  rrow;
    logic        r_row_inc;
    logic        even_line;
    logic [9:0]  lram_ra;
    logic [1:0]  lram_do = 2'd0;
    logic        line_done;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_sol;
    logic        req_ovf;

    logic [1:0]  ram [0:1023];
    beat_t       sb_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          beats_total = 0;
    int          beats_in_line = 0;
    int          done_count = 0;
    int          exp_done = 0;
    int          ready_pct = 100;
    bit          stalled_prev = 1'b0;
    logic [15:0] held_data = '0;

    gblcd_line_out dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame     (frame),
        .rrow      (rrow),
        .r_row_inc (r_row_inc),
        .even_line (even_line),
        .lram_ra   (lram_ra),
        .lram_do   (lram_do),
        .line_done (line_done),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_sol   (pix_sol),
        .req_ovf   (req_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) lram_do <= ram[lram_ra];

    initial begin
        pix_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            pix_ready = ($urandom_range(1, 100) <= ready_pct);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] refPixel(input int shade, input bit dim);
        int p, r, g, b;
        p = PAL[shade];
        if (dim) begin
            r = (p / 2048) / 2;
            g = ((p / 32) % 64) / 2;
            b = (p % 32) / 2;
            p = r * 2048 + g * 32 + b;
        end
        return 16'(p);
    endfunction

    // Queues the whole expected line (unless the request should be dropped) and drives the request
    task automatic applyStimulus(input int row, input bit even, input bit dropped);
        bit    dim;
        beat_t e;
`ifdef GBLCD_SCANLINE_DIM_EN
        dim = even;
`else
        dim = 1'b0;
`endif
        if (!dropped) begin
            for (int c = 0; c < SRC; c++) begin
                for (int k = 0; k < REPS; k++) begin
                    e.data = refPixel(int'(ram[row * 256 + c]), dim);
                    e.sol  = (c == 0) && (k == 0);
                    sb_q.push_back(e);
                end
            end
            exp_done++;
        end
        @(posedge clk);
        #1;
        r_row_inc = 1'b1;
        rrow      = 8'(($urandom_range(0, 63) << 2) | row);
        even_line = even;
        @(posedge clk);
        #1;
        r_row_inc = 1'b0;
        even_line = 1'($urandom);
        @(posedge clk);
        #1;
        rrow = 8'($urandom);
    endtask

    task automatic waitBeats(input int n);
        int target;
        int cyc;
        target = beats_total + n;
        cyc    = 0;
        while (beats_total < target && cyc < 5000) begin
            @(posedge clk);
            cyc++;
        end
        checkOutput("beat_wait", 32'(beats_total >= target), 32'd1);
        #1;
    endtask

    task automatic waitDone(input int target);
        int cyc;
        cyc = 0;
        while (done_count < target && cyc < 8000) begin
            @(posedge clk);
            cyc++;
        end
        checkOutput("line_done_wait", 32'(done_count >= target), 32'd1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (pix_valid && pix_ready) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_beat", {16'd0, pix_data}, 32'hDEAD_BEEF);
                end else begin
                    beat_t e;
                    e = sb_q.pop_front();
                    checkOutput("pix_data", {16'd0, pix_data}, {16'd0, e.data});
                    checkOutput("pix_sol", {31'd0, pix_sol}, {31'd0, e.sol});
                end
                beats_total++;
                beats_in_line++;
            end
            if (stalled_prev && pix_valid)
                checkOutput("stall_hold", {16'd0, pix_data}, {16'd0, held_data});
            stalled_prev = pix_valid && !pix_ready;
            held_data    = pix_data;
            if (line_done) begin
                done_count++;
                checkOutput("line_len", 32'(beats_in_line), 32'(OUTW));
                beats_in_line = 0;
            end
        end else begin
            stalled_prev = 1'b0;
        end
    end

    initial begin
        rst_n     = 1'b0;
        frame     = 1'b0;
        rrow      = 8'd0;
        r_row_inc = 1'b0;
        even_line = 1'b0;
        for (int a = 0; a < 1024; a++) ram[a] = 2'($urandom);
        for (int c = 0; c < 256; c++) ram[2 * 256 + c] = 2'(c % 4);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
        checkOutput("rst_pix_data", {16'd0, pix_data}, 32'd0);
        checkOutput("rst_pix_sol", {31'd0, pix_sol}, 32'd0);
        checkOutput("rst_line_done", {31'd0, line_done}, 32'd0);
        checkOutput("rst_lram_ra", {22'd0, lram_ra}, 32'd0);
        checkOutput("rst_req_ovf", {31'd0, req_ovf}, 32'd0);
        rst_n = 1'b1;

        ready_pct = 100;
        applyStimulus(2, 1'b0, 1'b0);
        waitDone(exp_done);

        ready_pct = 30;
        applyStimulus(2, 1'b0, 1'b0);
        waitDone(exp_done);

        // Queued second request runs back to back; a third while one is parked must be dropped
        ready_pct = 100;
        applyStimulus(2, 1'b0, 1'b0);
        waitBeats(50);
        applyStimulus(3, 1'b0, 1'b0);
        checkOutput("req_ovf_one_pending", {31'd0, req_ovf}, 32'd0);
        applyStimulus(1, 1'b0, 1'b1);
        checkOutput("req_ovf_set", {31'd0, req_ovf}, 32'd1);
        waitDone(exp_done);
        checkOutput("req_ovf_sticky", {31'd0, req_ovf}, 32'd1);

        ready_pct = 50;
        applyStimulus(0, 1'b0, 1'b0);
        waitBeats(100);
        frame = 1'b1;
        @(posedge clk);
        #1;
        frame = 1'b0;
        sb_q.delete();
        exp_done--;
        beats_in_line = 0;
        checkOutput("frame_pix_valid", {31'd0, pix_valid}, 32'd0);
        checkOutput("frame_req_ovf", {31'd0, req_ovf}, 32'd0);
        checkOutput("frame_line_done", {31'd0, line_done}, 32'd0);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("frame_no_done", 32'(done_count), 32'(exp_done));
        applyStimulus(1, 1'b0, 1'b0);
        waitDone(exp_done);

        ready_pct = 100;
        applyStimulus(3, 1'b0, 1'b0);
        waitBeats(50);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mid_rst_pix_valid", {31'd0, pix_valid}, 32'd0);
        checkOutput("mid_rst_pix_data", {16'd0, pix_data}, 32'd0);
        checkOutput("mid_rst_pix_sol", {31'd0, pix_sol}, 32'd0);
        checkOutput("mid_rst_line_done", {31'd0, line_done}, 32'd0);
        checkOutput("mid_rst_lram_ra", {22'd0, lram_ra}, 32'd0);
        sb_q.delete();
        exp_done--;
        beats_in_line = 0;
        rst_n = 1'b1;
        applyStimulus(2, 1'b0, 1'b0);
        waitDone(exp_done);

        ready_pct = 30;
        applyStimulus(2, 1'b1, 1'b0);
        waitDone(exp_done);
        applyStimulus(2, 1'b0, 1'b0);
        waitDone(exp_done);

        checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
        checkOutput("line_done_count", 32'(done_count), 32'(exp_done));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
